fb_copy_engine: RTL

Hardware back-to-front frame buffer copier. Reads every pixel of the back buffer in linear address order and writes it to the same address of the front buffer, one pixel per clock. Frame handoff uses a four-phase done/swap handshake with the producer (NIOS II) and starts only on a VGA end-of-frame pulse. It replaces the open-loop select/fb_we/swap logic between the processor and the two background_ram instances.

---
 rtl/fb_copy_engine.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fb_copy_engine.sv
// fb_copy_engine: copies the back frame buffer into the front frame buffer,
// one pixel per clock in linear address order. A copy starts only on a VGA
// end-of-frame pulse while the producer holds `done`. Completion is
// acknowledged with `swap`, which is held until the producer drops `done`.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   frame_end            one-cycle end-of-frame pulse (synchronous to clk)
//   done                 producer level: back buffer holds a full frame
//   swap                 acknowledge to producer: copy finished
//   bb_raddr / bb_rdata  back-buffer read port (registered RAM, 1-cycle latency)
//   fb_waddr / fb_wdata  front-buffer write port
//   fb_we                front-buffer write enable
//   busy                 copy in progress; back buffer must not be written
//   frame_count          completed copies, wraps at 16 bits
module fb_copy_engine #(
  parameter int unsigned NUMBER_COLORS = 9,
  parameter int unsigned WIDTH         = 320,
  parameter int unsigned HEIGHT        = 240,
  localparam int unsigned CW           = $clog2(NUMBER_COLORS) + 1,
  localparam int unsigned N            = WIDTH * HEIGHT,
  localparam int unsigned AW           = $clog2(N)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          frame_end,
  input  logic          done,
  output logic          swap,
  output logic [AW-1:0] bb_raddr,
  input  logic [CW-1:0] bb_rdata,
  output logic [AW-1:0] fb_waddr,
  output logic [CW-1:0] fb_wdata,
  output logic          fb_we,
  output logic          busy,
  output logic [15:0]   frame_count
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COPY = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_raddr;
  logic            r_issued_all;
  logic            r_wvalid;
  logic [AW-1:0]   r_waddr;
  logic            r_swap;
  logic            r_busy;
  logic [15:0]     r_frame_count;

  logic            w_start;
  logic            w_rd_valid;
  logic            w_last_wr;

  assign w_start    = (r_state == S_IDLE) && frame_end && done;
  // A read is issued every COPY cycle until address N-1 has gone out.
  assign w_rd_valid = (r_state == S_COPY) && !r_issued_all;
  assign w_last_wr  = r_wvalid && (r_waddr == LAST_ADDR);

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start)   w_next = S_COPY;
      S_COPY:  if (w_last_wr) w_next = S_ACK;
      S_ACK:   if (!done)     w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  // State register and registered handshake outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_swap        <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_state <= w_next;
      r_swap  <= (w_next == S_ACK);
      r_busy  <= (w_next == S_COPY);
      if ((r_state == S_COPY) && (w_next == S_ACK)) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  // Read address counter; holds at N-1 once the last read is issued
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_raddr      <= '0;
      r_issued_all <= 1'b0;
    end else if (w_start) begin
      r_raddr      <= '0;
      r_issued_all <= 1'b0;
    end else if (w_rd_valid) begin
      if (r_raddr == LAST_ADDR) begin
        r_issued_all <= 1'b1;
      end else begin
        r_raddr <= AW'(r_raddr + AW'(1));
      end
    end
  end

  // Write stage: one register behind the read, aligned with RAM read latency
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wvalid <= 1'b0;
      r_waddr  <= '0;
    end else begin
      r_wvalid <= w_rd_valid;
      if (w_rd_valid) begin
        r_waddr <= r_raddr;
      end
    end
  end

  assign swap        = r_swap;
  assign busy        = r_busy;
  assign frame_count = r_frame_count;
  assign bb_raddr    = r_raddr;
  assign fb_we       = r_wvalid;
  assign fb_waddr    = r_waddr;
  // RAM output already carries the previous cycle's read; gate so it reads 0 when idle
  assign fb_wdata    = r_wvalid ? bb_rdata : '0;

endmodule
